// File: rtl/fetch_pkg.sv
// Shared types and constants for the rv32 fetch stage: FSM states, buffer entry
// layout and word-alignment helper.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_nxt;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order instruction buffer. The head lives in its own register so the
// IF/ID outputs come straight from flops; a pop shifts the tail entry forward.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_pc_nxt,
    input  logic [XLEN-1:0] push_instr,
    input  logic            pop,
    output logic [1:0]      count,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_pc_nxt,
    output logic [XLEN-1:0] head_instr
);

    fetch_entry_t head_q;
    fetch_entry_t tail_q;
    fetch_entry_t new_entry;
    logic [1:0]   count_q;
    logic         do_pop;
    logic         do_push;

    assign new_entry = '{pc: push_pc, pc_nxt: push_pc_nxt, instr: push_instr};
    assign do_pop    = pop && (count_q != 2'd0) && !flush;
    assign do_push   = push && !flush && ((count_q != 2'd2) || do_pop);

    // NOTE: the storage is reset along with the count because the head register
    // drives ifid_* directly, and those outputs must read zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= new_entry;
                    else                 tail_q <= new_entry;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= new_entry;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= new_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count       = count_q;
    assign head_valid  = (count_q != 2'd0);
    assign head_pc     = head_q.pc;
    assign head_pc_nxt = head_q.pc_nxt;
    assign head_instr  = head_q.instr;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, keeps at most one imem request in flight,
// and discards stale responses after an execute-stage redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        ifid_valid,
    input  logic        ifid_ready,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_nxt,
    output logic [31:0] ifid_instr,
    output logic [31:0] fetch_pc
);

    localparam logic [1:0]      DEPTH = 2'(BUF_DEPTH);
    localparam logic [XLEN-1:0] INCR  = XLEN'(INSTR_BYTES);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [1:0]      count;
    logic            accept;
    logic            push;

    assign imem_req_valid = (state_q == REQ) && (count < DEPTH);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign fetch_pc       = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= word_align(RESET_VEC);
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        push      = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (accept) begin
                    pend_pc_d = pc_q;
                    // A request accepted alongside a redirect fetches the old path.
                    state_d   = redirect_valid ? FLUSH : WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    state_d = REQ;
                    if (!redirect_valid) begin
                        push = 1'b1;
                        pc_d = pend_pc_q + INCR;
                    end
                end else if (redirect_valid) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (imem_resp_valid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid) pc_d = word_align(redirect_pc);
    end

    fetch_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect_valid),
        .push        (push),
        .push_pc     (pend_pc_q),
        .push_pc_nxt (pend_pc_q + INCR),
        .push_instr  (imem_resp_data),
        .pop         (ifid_ready),
        .count       (count),
        .head_valid  (ifid_valid),
        .head_pc     (ifid_pc),
        .head_pc_nxt (ifid_pc_nxt),
        .head_instr  (ifid_instr)
    );

endmodule
